// File: rtl/scan_mux_pkg.sv
// rtl/scan_mux_pkg.sv - shared state encodings and board defaults for scan_mux
package scan_mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // 100 MHz board clock: 1 kHz scan rate, 20 ns dark time between digits
    localparam int DEFAULT_DIV          = 100000;
    localparam int DEFAULT_BLANK_CYCLES = 2;

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running prescaler producing one tick every DIV cycles
//   clk  : system clock
//   rst  : async active-high reset, count returns to 0
//   hold : freezes the count and suppresses tick
//   tick : high for one cycle when count == DIV-1
module scan_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!hold) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = !hold && (count == LAST);

endmodule

// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - time-multiplexed N:1 channel scanner with blanking and manual select
//   din     : packed channel words, channel k at din[k*WIDTH +: WIDTH]
//   en_mask : channels taking part in the scan
//   hold    : freeze the scan on the current channel
//   manual  : take the channel from man_sel instead of the scan
//   dout    : registered word of the current channel
//   sel     : current channel index
//   onehot  : active-high channel enable while showing, else 0
//   valid   : onehot is non-zero
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CHANNELS     = 4,
    parameter int SEL_W        = 2,
    parameter int DIV          = DEFAULT_DIV,
    parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       en_mask,
    input  logic                      hold,
    input  logic                      manual,
    input  logic [SEL_W-1:0]          man_sel,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          sel,
    output logic [CHANNELS-1:0]       onehot,
    output logic                      valid
);

    localparam int BW  = $clog2(BLANK_CYCLES + 1) + 1;
    localparam int SW1 = SEL_W + 1;
    localparam logic [BW-1:0]       BLANK_LAST = BW'((BLANK_CYCLES > 1) ? BLANK_CYCLES - 1 : 0);
    localparam logic [SW1-1:0]      CH_COUNT   = SW1'(CHANNELS);
    localparam logic [CHANNELS-1:0] ONE        = CHANNELS'(1);

    scan_state_t      state_q, state_n;
    logic [SEL_W-1:0] sel_q, sel_n;
    logic [BW-1:0]    bcnt_q, bcnt_n;
    logic [WIDTH-1:0] dout_q, word;
    logic [SEL_W-1:0] nxt, lowest;
    logic             tick, any_en, man_ok, blank_done;

    // The prescaler also stops in manual mode so the scan resumes from the held count.
    scan_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .hold (hold | manual),
        .tick (tick)
    );

    assign any_en     = |en_mask;
    assign man_ok     = ({1'b0, man_sel} < CH_COUNT) && (man_sel != sel_q);
    assign blank_done = (BLANK_CYCLES <= 1) || (bcnt_q == BLANK_LAST);

    // Scan from sel+CHANNELS (i.e. sel itself) down to sel+1 so the last hit
    // is the first enabled channel after sel; falls back to sel if it is alone.
    always_comb begin
        int j;
        j   = 0;
        nxt = sel_q;
        for (int i = CHANNELS; i >= 1; i--) begin
            j = (int'(sel_q) + i) % CHANNELS;
            if (en_mask[j[SEL_W-1:0]]) nxt = j[SEL_W-1:0];
        end
    end

    always_comb begin
        lowest = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (en_mask[k]) lowest = k[SEL_W-1:0];
        end
    end

    always_comb begin
        word = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_q == k[SEL_W-1:0]) word = din[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_n = state_q;
        sel_n   = sel_q;
        bcnt_n  = bcnt_q;
        if (!any_en) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    sel_n   = lowest;
                    bcnt_n  = '0;
                    state_n = BLANK;
                end
                BLANK: begin
                    if (manual && man_ok) begin
                        sel_n  = man_sel;
                        bcnt_n = '0;
                    end else if (blank_done) begin
                        state_n = SHOW;
                    end else begin
                        bcnt_n = bcnt_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (manual) begin
                        if (man_ok) begin
                            sel_n   = man_sel;
                            bcnt_n  = '0;
                            state_n = BLANK;
                        end
                    end else if ((tick || !en_mask[sel_q]) && (nxt != sel_q)) begin
                        // Losing the current channel's enable behaves like a tick.
                        sel_n   = nxt;
                        bcnt_n  = '0;
                        state_n = BLANK;
                    end
                end
                default: begin
                    state_n = BLANK;
                    bcnt_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BLANK;
            sel_q   <= '0;
            bcnt_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_n;
            sel_q   <= sel_n;
            bcnt_q  <= bcnt_n;
            dout_q  <= word;
        end
    end

    assign dout   = dout_q;
    assign sel    = sel_q;
    assign valid  = (state_q == SHOW);
    assign onehot = valid ? (ONE << sel_q) : '0;

endmodule

// File: tb/tb_scan_mux.sv
// tb/tb_scan_mux.sv - directed self-checking bench for scan_mux
module tb_scan_mux;

    localparam int WIDTH        = 4;
    localparam int CHANNELS     = 4;
    localparam int SEL_W        = 2;
    localparam int DIV          = 4;
    localparam int BLANK_CYCLES = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic [3:0]  en_mask;
    logic        hold;
    logic        manual;
    logic [1:0]  man_sel;
    logic [3:0]  dout;
    logic [1:0]  sel;
    logic [3:0]  onehot;
    logic        valid;

    int n_checks = 0;
    int n_pass   = 0;

    int seg_sel[$];
    int seg_dout[$];
    int seg_len[$];
    int seg_gap[$];
    int bad_onehot;

    always #5 clk = ~clk;

    scan_mux #(
        .WIDTH        (WIDTH),
        .CHANNELS     (CHANNELS),
        .SEL_W        (SEL_W),
        .DIV          (DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .en_mask (en_mask),
        .hold    (hold),
        .manual  (manual),
        .man_sel (man_sel),
        .dout    (dout),
        .sel     (sel),
        .onehot  (onehot),
        .valid   (valid)
    );

    // Records shown segments (channel, word, length) and the dark gap before each.
    task automatic run_scan(input int ncyc);
        logic       pv;
        logic [1:0] ps;
        int         gap;
        seg_sel.delete();
        seg_dout.delete();
        seg_len.delete();
        seg_gap.delete();
        bad_onehot = 0;
        pv  = 1'b0;
        ps  = 2'd0;
        gap = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (onehot !== (4'b0001 << sel)) bad_onehot++;
                if (!pv || sel != ps) begin
                    seg_sel.push_back(int'(sel));
                    seg_dout.push_back(int'(dout));
                    seg_len.push_back(1);
                    seg_gap.push_back(gap);
                end else begin
                    seg_len[seg_len.size()-1] += 1;
                end
                gap = 0;
            end else begin
                if (onehot !== 4'b0000) bad_onehot++;
                gap++;
            end
            pv = valid;
            ps = sel;
        end
    endtask

    task automatic test_reset();
        din     = 16'hDCBA;
        en_mask = 4'b1111;
        hold    = 1'b0;
        manual  = 1'b0;
        man_sel = 2'd0;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (sel !== 2'd0) $display("FAIL reset_sel: got %0d want 0", sel); else n_pass++;
        n_checks++; if (dout !== 4'h0) $display("FAIL reset_dout: got %h want 0", dout); else n_pass++;
        n_checks++; if (onehot !== 4'b0000) $display("FAIL reset_onehot: got %b want 0000", onehot); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_scan_order();
        int es[5] = '{0, 1, 2, 3, 0};
        int ed[5] = '{10, 11, 12, 13, 10};
        int gs, gd, gg, gl;
        run_scan(22);
        for (int i = 0; i < 5; i++) begin
            gs = (i < seg_sel.size()) ? seg_sel[i] : -1;
            gd = (i < seg_dout.size()) ? seg_dout[i] : -1;
            n_checks++;
            if (gs !== es[i] || gd !== ed[i])
                $display("FAIL scan_order_seg%0d: got sel %0d dout %0d want sel %0d dout %0d", i, gs, gd, es[i], ed[i]);
            else n_pass++;
        end
        for (int i = 1; i < 5; i++) begin
            gg = (i < seg_gap.size()) ? seg_gap[i] : -1;
            n_checks++;
            if (gg !== 1) $display("FAIL scan_blank_gap%0d: got %0d want 1", i, gg); else n_pass++;
        end
        for (int i = 1; i < 4; i++) begin
            gl = (i < seg_len.size()) ? seg_len[i] : -1;
            n_checks++;
            if (gl !== DIV - BLANK_CYCLES) $display("FAIL scan_show_len%0d: got %0d want %0d", i, gl, DIV - BLANK_CYCLES);
            else n_pass++;
        end
        n_checks++; if (bad_onehot !== 0) $display("FAIL scan_onehot: got %0d bad samples want 0", bad_onehot); else n_pass++;
    endtask

    task automatic test_masking();
        int es[4] = '{1, 3, 1, 3};
        int ed[4] = '{11, 13, 11, 13};
        int gs, gd, gg, bad;
        en_mask = 4'b1010;
        run_scan(24);
        for (int i = 0; i < 4; i++) begin
            gs = (i < seg_sel.size()) ? seg_sel[i] : -1;
            gd = (i < seg_dout.size()) ? seg_dout[i] : -1;
            n_checks++;
            if (gs !== es[i] || gd !== ed[i])
                $display("FAIL mask_seg%0d: got sel %0d dout %0d want sel %0d dout %0d", i, gs, gd, es[i], ed[i]);
            else n_pass++;
        end
        for (int i = 1; i < 4; i++) begin
            gg = (i < seg_gap.size()) ? seg_gap[i] : -1;
            n_checks++;
            if (gg !== 1) $display("FAIL mask_gap%0d: got %0d want 1", i, gg); else n_pass++;
        end
        n_checks++; if (bad_onehot !== 0) $display("FAIL mask_onehot: got %0d bad samples want 0", bad_onehot); else n_pass++;

        en_mask = 4'b0100;
        repeat (6) @(negedge clk);
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (valid !== 1'b1 || sel !== 2'd2 || onehot !== 4'b0100 || dout !== 4'hC) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL single_channel_steady: got %0d bad samples want 0", bad); else n_pass++;
    endtask

    task automatic test_all_masked();
        en_mask = 4'b0000;
        @(negedge clk);
        n_checks++; if (valid !== 1'b0 || onehot !== 4'b0000)
            $display("FAIL idle_outputs: got valid %b onehot %b want 0 0000", valid, onehot); else n_pass++;
        n_checks++; if (sel !== 2'd2) $display("FAIL idle_sel_frozen: got %0d want 2", sel); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++; if (sel !== 2'd2 || valid !== 1'b0)
            $display("FAIL idle_stays: got sel %0d valid %b want 2 0", sel, valid); else n_pass++;
        en_mask = 4'b0001;
        @(negedge clk);
        n_checks++; if (sel !== 2'd0 || valid !== 1'b0)
            $display("FAIL idle_exit_blank: got sel %0d valid %b want 0 0", sel, valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (onehot !== 4'b0001 || valid !== 1'b1 || dout !== 4'hA)
            $display("FAIL idle_exit_show: got onehot %b valid %b dout %h want 0001 1 a", onehot, valid, dout); else n_pass++;
    endtask

    task automatic test_manual();
        int bad;
        en_mask = 4'b1111;
        manual  = 1'b1;
        man_sel = 2'd2;
        @(negedge clk);
        n_checks++; if (sel !== 2'd2 || valid !== 1'b0)
            $display("FAIL manual_blank: got sel %0d valid %b want 2 0", sel, valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (onehot !== 4'b0100 || dout !== 4'hC)
            $display("FAIL manual_show: got onehot %b dout %h want 0100 c", onehot, dout); else n_pass++;
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (valid !== 1'b1 || sel !== 2'd2 || onehot !== 4'b0100 || dout !== 4'hC) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL manual_held: got %0d bad samples want 0", bad); else n_pass++;

        en_mask = 4'b0111;
        man_sel = 2'd3;
        @(negedge clk);
        n_checks++; if (sel !== 2'd3 || valid !== 1'b0)
            $display("FAIL manual_masked_sel: got sel %0d valid %b want 3 0", sel, valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (onehot !== 4'b1000 || dout !== 4'hD)
            $display("FAIL manual_masked_show: got onehot %b dout %h want 1000 d", onehot, dout); else n_pass++;

        manual = 1'b0;
        @(negedge clk);
        n_checks++; if (sel !== 2'd0 || valid !== 1'b0)
            $display("FAIL manual_exit_skip: got sel %0d valid %b want 0 0", sel, valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (onehot !== 4'b0001 || valid !== 1'b1)
            $display("FAIL manual_exit_show: got onehot %b valid %b want 0001 1", onehot, valid); else n_pass++;
    endtask

    task automatic test_hold();
        int         t;
        int         bad;
        logic [1:0] s;
        en_mask = 4'b1111;
        t = 0;
        while (valid === 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_checks++; if (valid !== 1'b0) $display("FAIL hold_sync_timeout: got valid %b want 0", valid); else n_pass++;
        hold = 1'b1;
        s    = sel;
        bad  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sel !== s || valid !== 1'b1) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL hold_frozen: got %0d bad samples want 0", bad); else n_pass++;
        hold = 1'b0;
        bad  = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (sel !== s || valid !== 1'b1) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL hold_release_early: got %0d bad samples want 0", bad); else n_pass++;
        @(negedge clk);
        n_checks++; if (sel !== s + 2'd1 || valid !== 1'b0)
            $display("FAIL hold_resume: got sel %0d valid %b want %0d 0", sel, valid, s + 2'd1); else n_pass++;
    endtask

    task automatic test_mid_reset_live_data();
        int t;
        t = 0;
        while (valid !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (sel !== 2'd0 || dout !== 4'h0 || onehot !== 4'b0000 || valid !== 1'b0)
            $display("FAIL async_reset: got sel %0d dout %h onehot %b valid %b want 0 0 0000 0", sel, dout, onehot, valid);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (valid !== 1'b1 || sel !== 2'd0 || dout !== 4'hA)
            $display("FAIL post_reset_show: got valid %b sel %0d dout %h want 1 0 a", valid, sel, dout); else n_pass++;
        din = 16'hDCB5;
        @(negedge clk);
        n_checks++; if (dout !== 4'h5 || sel !== 2'd0)
            $display("FAIL live_din: got dout %h sel %0d want 5 0", dout, sel); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_scan_order();
        test_masking();
        test_all_masked();
        test_manual();
        test_hold();
        test_mid_reset_live_data();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
